vga_sync_gen: RTL and testbench

- VGA raster timing generator for the radar display.
- Sits directly downstream of the pixel-rate divider and consumes its pixel-rate strobe on the system clock.
- Produces hsync/vsync, a video-active flag, the current pixel coordinates, and line/frame start strobes for the radar rendering and colour stages.
- Default timing is 640x480@60 (800x525 total), with 4-bit-per-channel colour on Nexys4.

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_axis_counter.sv | 70 +++++++
 rtl/vga_sync_gen.sv | 125 ++++++++++++
 tb/tb_vga_sync_gen.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, raster phase encoding and test-pattern colour table.
package vga_timing_pkg;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

  localparam int unsigned DefHTotal = DefHActive + DefHFp + DefHSync + DefHBp;
  localparam int unsigned DefVTotal = DefVActive + DefVFp + DefVSync + DefVBp;

  typedef enum logic [1:0] {ACT, FP, SYNC, BP} phase_e;

  // 4-bit-per-channel RGB, bars left to right.
  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    logic [11:0] c;
    c = 12'h000;
    case (idx)
      3'd0:    c = 12'hFFF;
      3'd1:    c = 12'hFF0;
      3'd2:    c = 12'h0FF;
      3'd3:    c = 12'h0F0;
      3'd4:    c = 12'hF0F;
      3'd5:    c = 12'hF00;
      3'd6:    c = 12'h00F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with load-to-max, carry on wrap, phase FSM and sync decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned Active     = 640,
  parameter int unsigned FrontPorch = 16,
  parameter int unsigned SyncWidth  = 96,
  parameter int unsigned BackPorch  = 48,
  parameter bit          SyncPol    = 1'b0,
  parameter int unsigned CntW       = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            load_i,
  output logic [CntW-1:0] cnt_o,
  output logic            carry_o,
  output logic            sync_o,
  output logic            active_nxt_o
);

  localparam logic [CntW-1:0] MaxCnt    = CntW'(Active + FrontPorch + SyncWidth + BackPorch - 1);
  localparam logic [CntW-1:0] FpStart   = CntW'(Active);
  localparam logic [CntW-1:0] SyncStart = CntW'(Active + FrontPorch);
  localparam logic [CntW-1:0] BpStart   = CntW'(Active + FrontPorch + SyncWidth);

  logic [CntW-1:0] cnt_q, cnt_d;
  phase_e          phase_q, phase_d;
  logic            sync_q, sync_d;

  assign carry_o = en_i & ~load_i & (cnt_q == MaxCnt);

  // Phase is decoded from the next count so every output lines up with cnt_o.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (load_i) begin
      cnt_d   = MaxCnt;
      phase_d = BP;
    end else if (en_i) begin
      cnt_d = (cnt_q == MaxCnt) ? '0 : cnt_q + CntW'(1);
      unique case (phase_q)
        ACT:     if (cnt_d == FpStart)   phase_d = FP;
        FP:      if (cnt_d == SyncStart) phase_d = SYNC;
        SYNC:    if (cnt_d == BpStart)   phase_d = BP;
        BP:      if (cnt_d == '0)        phase_d = ACT;
        default: phase_d = BP;
      endcase
    end
    sync_d = (phase_d == SYNC) ? SyncPol : ~SyncPol;
  end

  assign active_nxt_o = (phase_d == ACT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= MaxCnt;
      phase_q <= BP;
      sync_q  <= ~SyncPol;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      sync_q  <= sync_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign sync_o = sync_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator; VGA_TEST_PATTERN_EN adds an 8-bar colour test pattern on rgb.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DefHActive,
  parameter int unsigned H_FP      = DefHFp,
  parameter int unsigned H_SYNC    = DefHSync,
  parameter int unsigned H_BP      = DefHBp,
  parameter int unsigned V_ACTIVE  = DefVActive,
  parameter int unsigned V_FP      = DefVFp,
  parameter int unsigned V_SYNC    = DefVSync,
  parameter int unsigned V_BP      = DefVBp,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CNT_W     = 10
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             pix_tick,
  input  logic             frame_rst,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [11:0]      rgb
`endif
);

  logic h_carry, v_carry;
  logic h_act_nxt, v_act_nxt;
  logic video_d;
  logic video_q, line_q, frame_q;

  vga_axis_counter #(
    .Active     (H_ACTIVE),
    .FrontPorch (H_FP),
    .SyncWidth  (H_SYNC),
    .BackPorch  (H_BP),
    .SyncPol    (HSYNC_POL),
    .CntW       (CNT_W)
  ) u_h (
    .clk_i        (clk_in),
    .rst_ni       (rst_n),
    .en_i         (pix_tick),
    .load_i       (frame_rst),
    .cnt_o        (pix_x),
    .carry_o      (h_carry),
    .sync_o       (hsync),
    .active_nxt_o (h_act_nxt)
  );

  vga_axis_counter #(
    .Active     (V_ACTIVE),
    .FrontPorch (V_FP),
    .SyncWidth  (V_SYNC),
    .BackPorch  (V_BP),
    .SyncPol    (VSYNC_POL),
    .CntW       (CNT_W)
  ) u_v (
    .clk_i        (clk_in),
    .rst_ni       (rst_n),
    .en_i         (h_carry),
    .load_i       (frame_rst),
    .cnt_o        (pix_y),
    .carry_o      (v_carry),
    .sync_o       (vsync),
    .active_nxt_o (v_act_nxt)
  );

  assign video_d = h_act_nxt & v_act_nxt;

  // A vertical carry implies a horizontal wrap on the same edge, i.e. (0, 0).
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      video_q <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      video_q <= video_d;
      line_q  <= h_carry;
      frame_q <= v_carry;
    end
  end

  assign video_on    = video_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BarW = CNT_W'(H_ACTIVE / 8);

  logic [CNT_W-1:0] x_nxt;
  logic [CNT_W-1:0] bar_idx;
  logic [11:0]      rgb_d, rgb_q;

  // frame_rst needs no special case: video_d is already low then.
  always_comb begin
    x_nxt = pix_x;
    if (pix_tick) begin
      x_nxt = h_carry ? '0 : pix_x + CNT_W'(1);
    end
    bar_idx = x_nxt / BarW;
    rgb_d   = 12'h000;
    if (video_d) begin
      rgb_d = (bar_idx > CNT_W'(7)) ? bar_colour(3'd7) : bar_colour(bar_idx[2:0]);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= 12'h000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb = rgb_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench: default 640x480 instance plus a shrunken-timing instance for whole-frame checks.
module tb_vga_sync_gen;

  localparam int AHA = 640, AHF = 16, AHS = 96, AHB = 48;
  localparam int AVA = 480, AVF = 10, AVS = 2, AVB = 33;
  localparam int AHT = AHA + AHF + AHS + AHB;
  localparam int AVT = AVA + AVF + AVS + AVB;
  localparam bit AHP = 1'b0, AVP = 1'b0;

  localparam int BHA = 24, BHF = 2, BHS = 3, BHB = 4;
  localparam int BVA = 12, BVF = 2, BVS = 2, BVB = 3;
  localparam int BHT = BHA + BHF + BHS + BHB;
  localparam int BVT = BVA + BVF + BVS + BVB;
  localparam bit BHP = 1'b1, BVP = 1'b0;

  logic clk = 1'b0;
  logic rst_n, tick_a, frst_a, tick_b, frst_b;
  logic hsync_a, vsync_a, video_a, ls_a, fs_a;
  logic hsync_b, vsync_b, video_b, ls_b, fs_b;
  logic [9:0] x_a, y_a, x_b, y_b;
`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] rgb_a, rgb_b;
`endif

  int checks = 0;
  int errors = 0;
  int ax, ay, bx, by;
  bit als, afs, bls, bfs;

  always #5 clk = ~clk;

  vga_sync_gen dut_a (
    .clk_in      (clk),
    .rst_n       (rst_n),
    .pix_tick    (tick_a),
    .frame_rst   (frst_a),
    .hsync       (hsync_a),
    .vsync       (vsync_a),
    .video_on    (video_a),
    .pix_x       (x_a),
    .pix_y       (y_a),
    .line_start  (ls_a),
    .frame_start (fs_a)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .rgb         (rgb_a)
`endif
  );

  vga_sync_gen #(
    .H_ACTIVE  (BHA), .H_FP (BHF), .H_SYNC (BHS), .H_BP (BHB),
    .V_ACTIVE  (BVA), .V_FP (BVF), .V_SYNC (BVS), .V_BP (BVB),
    .HSYNC_POL (BHP), .VSYNC_POL (BVP), .CNT_W (10)
  ) dut_b (
    .clk_in      (clk),
    .rst_n       (rst_n),
    .pix_tick    (tick_b),
    .frame_rst   (frst_b),
    .hsync       (hsync_b),
    .vsync       (vsync_b),
    .video_on    (video_b),
    .pix_x       (x_b),
    .pix_y       (y_b),
    .line_start  (ls_b),
    .frame_start (fs_b)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .rgb         (rgb_b)
`endif
  );

  // Reference: raster position as plain integers, outputs from range tests on them.
  function automatic logic [24:0] exp_vec(input int x, input int y, input bit ls, input bit fs,
                                          input int ha, input int hf, input int hs,
                                          input int va, input int vf, input int vs,
                                          input bit hp, input bit vp);
    bit hsy, vsy, vid;
    hsy = (x >= ha + hf && x < ha + hf + hs) ? hp : !hp;
    vsy = (y >= va + vf && y < va + vf + vs) ? vp : !vp;
    vid = (x < ha) && (y < va);
    return {hsy, vsy, vid, 10'(x), 10'(y), ls, fs};
  endfunction

  function automatic logic [24:0] exp_a();
    return exp_vec(ax, ay, als, afs, AHA, AHF, AHS, AVA, AVF, AVS, AHP, AVP);
  endfunction

  function automatic logic [24:0] exp_b();
    return exp_vec(bx, by, bls, bfs, BHA, BHF, BHS, BVA, BVF, BVS, BHP, BVP);
  endfunction

  function automatic logic [24:0] got_a();
    return {hsync_a, vsync_a, video_a, x_a, y_a, ls_a, fs_a};
  endfunction

  function automatic logic [24:0] got_b();
    return {hsync_b, vsync_b, video_b, x_b, y_b, ls_b, fs_b};
  endfunction

  function automatic logic [11:0] exp_rgb(input int x, input int y, input int ha, input int va);
    int idx;
    if (x >= ha || y >= va) return 12'h000;
    idx = x / (ha / 8);
    case (idx)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  task automatic model_adv(inout int x, inout int y, inout bit ls, inout bit fs,
                           input int ht, input int vt, input bit tick, input bit frst);
    if (frst) begin
      x = ht - 1; y = vt - 1; ls = 0; fs = 0;
    end else if (tick) begin
      x = x + 1;
      if (x == ht) begin
        x = 0;
        y = (y + 1) % vt;
      end
      ls = (x == 0);
      fs = (x == 0) && (y == 0);
    end else begin
      ls = 0; fs = 0;
    end
  endtask

  task automatic model_reset();
    ax = AHT - 1; ay = AVT - 1; als = 0; afs = 0;
    bx = BHT - 1; by = BVT - 1; bls = 0; bfs = 0;
  endtask

  task automatic step(input bit ta, input bit fa, input bit tb_, input bit fb);
    tick_a = ta; frst_a = fa; tick_b = tb_; frst_b = fb;
    @(posedge clk);
    model_adv(ax, ay, als, afs, AHT, AVT, ta, fa);
    model_adv(bx, by, bls, bfs, BHT, BVT, tb_, fb);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick_a = 0; frst_a = 0; tick_b = 0; frst_b = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got_a() !== exp_a()) begin
      errors++; $display("FAIL reset_a: got %h expected %h", got_a(), exp_a());
    end
    checks++;
    if (got_b() !== exp_b()) begin
      errors++; $display("FAIL reset_b: got %h expected %h", got_b(), exp_b());
    end
`ifdef VGA_TEST_PATTERN_EN
    checks++;
    if (rgb_a !== 12'h000) begin
      errors++; $display("FAIL reset_rgb: got %h expected 000", rgb_a);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_tick();
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 4; c++) begin
        step(c == 0, 0, 0, 0);
        checks++;
        if (got_a() !== exp_a()) begin
          errors++; $display("FAIL first_tick i=%0d c=%0d: got %h expected %h", i, c, got_a(), exp_a());
        end
        if (i == 0 && c == 0) begin
          checks++;
          if ({video_a, ls_a, fs_a, x_a, y_a} !== {3'b111, 20'd0}) begin
            errors++;
            $display("FAIL first_origin: got v=%b ls=%b fs=%b x=%0d y=%0d expected 1 1 1 0 0",
                     video_a, ls_a, fs_a, x_a, y_a);
          end
        end
      end
    end
  endtask

  task automatic test_line();
    int  last_ls = -1;
    int  low_run = 0;
    bit  prev_h, prev_v;
    prev_h = hsync_a; prev_v = video_a;
    for (int t = 0; t < 1600; t++) begin
      step(1, 0, 0, 0);
      checks++;
      if (got_a() !== exp_a()) begin
        errors++; $display("FAIL line t=%0d: got %h expected %h", t, got_a(), exp_a());
      end
      if (ls_a) begin
        if (last_ls >= 0) begin
          checks++;
          if (t - last_ls != 800) begin
            errors++; $display("FAIL line_spacing: got %0d expected 800", t - last_ls);
          end
        end
        last_ls = t;
      end
      if (!hsync_a) begin
        if (prev_h) begin
          checks++;
          if (x_a !== 10'd656) begin
            errors++; $display("FAIL hsync_fall: got x=%0d expected 656", x_a);
          end
        end
        low_run++;
      end else begin
        if (!prev_h && low_run > 0) begin
          checks++;
          if (x_a !== 10'd752 || low_run != 96) begin
            errors++;
            $display("FAIL hsync_rise: got x=%0d width=%0d expected 752 96", x_a, low_run);
          end
        end
        low_run = 0;
      end
      if (prev_v && !video_a) begin
        checks++;
        if (x_a !== 10'd640) begin
          errors++; $display("FAIL video_fall: got x=%0d expected 640", x_a);
        end
      end
      prev_h = hsync_a; prev_v = video_a;
    end
  endtask

  task automatic test_hold();
    int n;
    n = (300 - ax + AHT) % AHT;
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    checks++;
    if (x_a !== 10'd300) begin
      errors++; $display("FAIL hold_setup: got x=%0d expected 300", x_a);
    end
    for (int i = 0; i < 50; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if (got_a() !== exp_a()) begin
        errors++; $display("FAIL hold i=%0d: got %h expected %h", i, got_a(), exp_a());
      end
    end
    step(1, 0, 0, 0);
    checks++;
    if (x_a !== 10'd301 || got_a() !== exp_a()) begin
      errors++; $display("FAIL hold_resume: got %h expected %h", got_a(), exp_a());
    end
  endtask

  task automatic test_rgb();
`ifdef VGA_TEST_PATTERN_EN
    int n;
    n = (85 - ax + AHT) % AHT;
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    checks++;
    if (rgb_a !== 12'hFF0 || x_a !== 10'd85) begin
      errors++; $display("FAIL rgb_yellow: got rgb=%h x=%0d expected FF0 85", rgb_a, x_a);
    end
    for (int i = 0; i < AHT; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if (rgb_a !== exp_rgb(ax, ay, AHA, AVA)) begin
        errors++;
        $display("FAIL rgb_line x=%0d: got %h expected %h", ax, rgb_a, exp_rgb(ax, ay, AHA, AVA));
      end
    end
`endif
  endtask

  task automatic test_frames();
    int last_fs = -1;
    int vs_cnt = 0;
    int bad_video = 0;
    for (int t = 1; t <= 2 * BHT * BVT + 1; t++) begin
      step(0, 0, 1, 0);
      checks++;
      if (got_b() !== exp_b()) begin
        errors++; $display("FAIL frames t=%0d: got %h expected %h", t, got_b(), exp_b());
      end
      if (fs_b) begin
        if (last_fs >= 0) begin
          checks++;
          if (t - last_fs != BHT * BVT) begin
            errors++; $display("FAIL frame_spacing: got %0d expected %0d", t - last_fs, BHT * BVT);
          end
        end
        last_fs = t;
      end
      if (t <= 2 * BHT * BVT && vsync_b == BVP) vs_cnt++;
      if (video_b && y_b >= 10'(BVA)) bad_video++;
    end
    checks++;
    if (vs_cnt != 2 * BVS * BHT) begin
      errors++; $display("FAIL vsync_width: got %0d expected %0d", vs_cnt, 2 * BVS * BHT);
    end
    checks++;
    if (bad_video != 0) begin
      errors++; $display("FAIL video_vblank: got %0d expected 0", bad_video);
    end
  endtask

  task automatic test_frame_rst();
    int n;
    n = ((8 * BHT + 10) - (by * BHT + bx) + BHT * BVT) % (BHT * BVT);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0);
    checks++;
    if (x_b !== 10'd10 || y_b !== 10'd8) begin
      errors++; $display("FAIL frst_setup: got (%0d,%0d) expected (10,8)", x_b, y_b);
    end
    step(0, 0, 1, 1);
    checks++;
    if ({x_b, y_b, video_b, ls_b, fs_b} !== {10'(BHT - 1), 10'(BVT - 1), 3'b000}) begin
      errors++; $display("FAIL frst_force: got x=%0d y=%0d v=%b", x_b, y_b, video_b);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    checks++;
    if (got_b() !== exp_b()) begin
      errors++; $display("FAIL frst_idle: got %h expected %h", got_b(), exp_b());
    end
    step(0, 0, 1, 0);
    checks++;
    if ({x_b, y_b, ls_b, fs_b} !== {20'd0, 2'b11} || got_b() !== exp_b()) begin
      errors++; $display("FAIL frst_release: got %h expected %h", got_b(), exp_b());
    end
  endtask

  task automatic test_random();
    bit ta, fa, tb_, fb;
    for (int i = 0; i < 3000; i++) begin
      ta  = ($urandom_range(0, 1) == 1);
      fa  = ($urandom_range(0, 99) == 0);
      tb_ = ($urandom_range(0, 3) != 0);
      fb  = ($urandom_range(0, 49) == 0);
      step(ta, fa, tb_, fb);
      checks++;
      if (got_a() !== exp_a() || got_b() !== exp_b()) begin
        errors++;
        $display("FAIL random i=%0d: got %h/%h expected %h/%h", i, got_a(), got_b(), exp_a(), exp_b());
      end
`ifdef VGA_TEST_PATTERN_EN
      checks++;
      if (rgb_b !== exp_rgb(bx, by, BHA, BVA)) begin
        errors++;
        $display("FAIL random_rgb i=%0d: got %h expected %h", i, rgb_b, exp_rgb(bx, by, BHA, BVA));
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 20; i++) step(1, 0, 1, 0);
    tick_a = 0; tick_b = 0; frst_a = 0; frst_b = 0;
    @(posedge clk);
    model_adv(ax, ay, als, afs, AHT, AVT, 0, 0);
    model_adv(bx, by, bls, bfs, BHT, BVT, 0, 0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (got_a() !== exp_a() || got_b() !== exp_b()) begin
      errors++;
      $display("FAIL async_reset: got %h/%h expected %h/%h", got_a(), got_b(), exp_a(), exp_b());
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 1, 0);
    checks++;
    if (got_a() !== exp_a() || got_b() !== exp_b() || fs_a !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_tick: got %h/%h expected %h/%h", got_a(), got_b(), exp_a(), exp_b());
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_line();
    test_hold();
    test_rgb();
    test_frames();
    test_frame_rst();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
